// File: rtl/trng_ctrl_pkg.sv
// trng_ctrl_pkg: shared state encoding, word width and default parameters for the TRNG controller
package trng_ctrl_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WARMUP  = 3'd1,
      COLLECT = 3'd2,
      HOLD    = 3'd3,
      FAIL    = 3'd4
   } state_e;
   localparam int WORD_W = 32;
   localparam int unsigned DEF_WARMUP_CYCLES = 64;
   localparam int unsigned DEF_SAMPLE_DIV = 4;
   localparam int unsigned DEF_REP_LIMIT = 16;
endpackage

// File: rtl/trng_health.sv
// trng_health: repetition-count health test; fail rises once the identical-sample run reaches REP_LIMIT
module trng_health
   import trng_ctrl_pkg::*;
#(
   parameter int unsigned REP_LIMIT = DEF_REP_LIMIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic smp,
   input  logic smp_bit,
   input  logic clr,
   output logic fail
);
   logic [7:0] run_q, run_d;
   logic       last_q, last_d;
   logic       fail_q, fail_d;

   always_comb begin
      run_d  = clr ? 8'd0 : run_q;
      last_d = last_q;
      if (smp && !clr) begin
         run_d  = (run_q != 8'd0 && smp_bit == last_q) ? run_q + 8'd1 : 8'd1;
         last_d = smp_bit;
      end
      fail_d = run_d >= 8'(REP_LIMIT);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         run_q  <= 8'd0;
         last_q <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         run_q  <= run_d;
         last_q <= last_d;
         fail_q <= fail_d;
      end

   assign fail = fail_q;
endmodule

// File: rtl/trng_ctrl.sv
// trng_ctrl: warms up the oscillator, assembles 32-bit words from divided samples and locks out on health failure
module trng_ctrl
   import trng_ctrl_pkg::*;
#(
   parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
   parameter int unsigned SAMPLE_DIV    = DEF_SAMPLE_DIV,
   parameter int unsigned REP_LIMIT     = DEF_REP_LIMIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              clr_fail,
   input  logic              trng_bit,
   output logic              trng_en,
   output logic [WORD_W-1:0] rnd_data,
   output logic              rnd_valid,
   input  logic              rnd_ready,
   output logic              busy,
   output logic              health_fail
);
   localparam int WW = $clog2(WARMUP_CYCLES);
   localparam int CW = $clog2(WORD_W + 1);

   state_e            state_q, state_d;
   logic [WW-1:0]     warm_q, warm_d;
   logic [7:0]        div_q, div_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              pend_q, pend_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic              hf_q, hf_d;
   logic              smp, hclr, hfail;

   trng_health #(.REP_LIMIT(REP_LIMIT)) u_health (
      .clk     (clk),
      .rst_n   (rst_n),
      .smp     (smp),
      .smp_bit (trng_bit),
      .clr     (hclr),
      .fail    (hfail)
   );

   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      pend_d  = pend_q;
      smp     = 1'b0;
      hclr    = 1'b0;
      case (state_q)
         IDLE: begin
            warm_d  = '0;
            state_d = (start && !stop) ? WARMUP : IDLE;
         end
         WARMUP: begin
            hclr   = 1'b1;
            warm_d = warm_q + 1'b1;
            div_d  = 8'd0;
            cnt_d  = '0;
            state_d = stop ? IDLE : (warm_q == WW'(WARMUP_CYCLES - 1)) ? COLLECT : WARMUP;
         end
         COLLECT: begin
            // completion and health verdicts are taken the cycle after the sample that produced them
            if (stop) state_d = IDLE;
            else if (hfail) state_d = FAIL;
            else if (cnt_q == CW'(WORD_W)) state_d = HOLD;
            else begin
               smp    = div_q == 8'(SAMPLE_DIV - 1);
               div_d  = smp ? 8'd0 : div_q + 8'd1;
               cnt_d  = cnt_q + CW'(smp);
               data_d = smp ? {data_q[WORD_W-2:0], trng_bit} : data_q;
            end
         end
         HOLD: begin
            pend_d = pend_q | stop;
            if (valid_q && rnd_ready) begin
               state_d = (pend_q || stop) ? IDLE : COLLECT;
               div_d   = 8'd0;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end
         end
         FAIL: state_d = clr_fail ? IDLE : FAIL;
         default: state_d = IDLE;
      endcase
      busy_d  = state_d inside {WARMUP, COLLECT, HOLD};
      valid_d = state_d == HOLD;
      hf_d    = state_d == FAIL;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         warm_q  <= '0;
         div_q   <= 8'd0;
         cnt_q   <= '0;
         data_q  <= '0;
         pend_q  <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         hf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         hf_q    <= hf_d;
      end

   assign trng_en     = busy_q;
   assign busy        = busy_q;
   assign rnd_valid   = valid_q;
   assign rnd_data    = data_q;
   assign health_fail = hf_q;
endmodule

// File: tb/tb_trng_ctrl.sv
// tb_trng_ctrl: scenario tasks with a word scoreboard for trng_ctrl (WARMUP=8, DIV=2, LIMIT=4)
module tb_trng_ctrl;
   localparam int W = 8;
   localparam int D = 2;
   localparam int L = 4;

   logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, stop = 1'b0, clr_fail = 1'b0;
   logic        trng_bit = 1'b0, rnd_ready = 1'b0;
   logic        trng_en, rnd_valid, busy, health_fail;
   logic [31:0] rnd_data;
   int          n_chk = 0, n_fail = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   trng_ctrl #(.WARMUP_CYCLES(W), .SAMPLE_DIV(D), .REP_LIMIT(L)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .clr_fail    (clr_fail),
      .trng_bit    (trng_bit),
      .trng_en     (trng_en),
      .rnd_data    (rnd_data),
      .rnd_valid   (rnd_valid),
      .rnd_ready   (rnd_ready),
      .busy        (busy),
      .health_fail (health_fail)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drive_word(input logic [31:0] w, input int off, output int lat);
      int s;
      exp_q.push_back(w);
      lat = -1;
      for (int n = 1; n <= off + 32 * D + 20; n++) begin
         if (n > off) begin
            s = (n - off - 1) / D;
            if (s < 32) trng_bit = w[31-s];
         end
         tick();
         if (rnd_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic take_word(input int stall);
      logic [31:0] exp;
      exp = 32'd0;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got word %h with nothing expected", rnd_data);
      end else exp = exp_q.pop_front();
      for (int i = 0; i < stall; i++) begin
         n_chk++;
         if (rnd_valid !== 1'b1 || rnd_data !== exp) begin
            n_fail++;
            $display("FAIL hold_stable[%0d]: got valid=%b data=%h exp valid=1 data=%h", i, rnd_valid, rnd_data, exp);
         end
         tick();
      end
      n_chk++;
      if (rnd_valid !== 1'b1 || rnd_data !== exp) begin
         n_fail++;
         $display("FAIL word: got valid=%b data=%h exp valid=1 data=%h", rnd_valid, rnd_data, exp);
      end
      rnd_ready = 1'b1;
      tick();
      rnd_ready = 1'b0;
   endtask

   task automatic check_lat(input string name, input int lat, input int exp);
      n_chk++;
      if (lat !== exp) begin
         n_fail++;
         $display("FAIL %s: got latency %0d exp %0d", name, lat, exp);
      end
   endtask

   task automatic watch_no_valid(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (rnd_valid) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: got rnd_valid seen=%b exp 0", name, seen);
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      n_chk++;
      if ({trng_en, rnd_valid, busy, health_fail, rnd_data} !== 36'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h exp 0", {trng_en, rnd_valid, busy, health_fail, rnd_data});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_chk++;
      if (busy !== 1'b0 || trng_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b en=%b exp 0 0", busy, trng_en);
      end
   endtask

   task automatic test_words();
      int lat;
      pulse_start();
      drive_word(32'hAAAAAAAA, W, lat);
      check_lat("first_word_latency", lat, 1 + W + 32 * D);
      take_word(10);
      drive_word(32'h33333333, 0, lat);
      check_lat("next_word_latency", lat, 1 + 32 * D);
      take_word(0);
      drive_word(32'h71C71C71, 0, lat);
      check_lat("run3_word_latency", lat, 1 + 32 * D);
   endtask

   task automatic test_stop_hold();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_chk++;
      if (rnd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stop_hold_valid: got %b exp 1", rnd_valid);
      end
      take_word(3);
      n_chk++;
      if ({busy, trng_en, rnd_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL stop_hold_idle: got busy/en/valid=%b exp 000", {busy, trng_en, rnd_valid});
      end
      watch_no_valid("stop_hold_no_word", 100);
   endtask

   task automatic test_health();
      trng_bit = 1'b1;
      pulse_start();
      repeat (W + 4 * D) tick();
      n_chk++;
      if ({health_fail, trng_en} !== 2'b01) begin
         n_fail++;
         $display("FAIL health_pre: got hf/en=%b exp 01", {health_fail, trng_en});
      end
      tick();
      n_chk++;
      if ({health_fail, trng_en, rnd_valid, busy} !== 4'b1000) begin
         n_fail++;
         $display("FAIL health_trip: got hf/en/valid/busy=%b exp 1000", {health_fail, trng_en, rnd_valid, busy});
      end
      start = 1'b1;
      repeat (5) tick();
      start = 1'b0;
      n_chk++;
      if ({health_fail, trng_en, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL health_start_ignored: got hf/en/busy=%b exp 100", {health_fail, trng_en, busy});
      end
      clr_fail = 1'b1;
      tick();
      clr_fail = 1'b0;
      n_chk++;
      if ({health_fail, trng_en, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL health_clear: got hf/en/busy=%b exp 000", {health_fail, trng_en, busy});
      end
   endtask

   task automatic test_stop_collect();
      int s;
      pulse_start();
      for (int n = 1; n <= W + 10 * D; n++) begin
         s = (n - W - 1) / D;
         if (n > W) trng_bit = (s % 2 == 0);
         tick();
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_chk++;
      if ({busy, trng_en, rnd_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL stop_collect: got busy/en/valid=%b exp 000", {busy, trng_en, rnd_valid});
      end
      watch_no_valid("stop_collect_no_word", 100);
   endtask

   task automatic test_start_stop();
      start = 1'b1;
      stop  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_chk++;
         if ({trng_en, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_stop[%0d]: got en/busy=%b exp 00", i, {trng_en, busy});
         end
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_async_reset();
      int lat;
      trng_bit = 1'b1;
      pulse_start();
      repeat (W + 3 * D) tick();
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({trng_en, rnd_valid, busy, health_fail, rnd_data} !== 36'd0) begin
         n_fail++;
         $display("FAIL async_reset: got %h exp 0", {trng_en, rnd_valid, busy, health_fail, rnd_data});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) tick();
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_needs_start: got busy=%b exp 0", busy);
      end
      pulse_start();
      drive_word(32'h5A5A5A5A, W, lat);
      check_lat("post_reset_latency", lat, 1 + W + 32 * D);
      take_word(0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_words();
      test_stop_hold();
      test_health();
      test_stop_collect();
      test_start_stop();
      test_async_reset();
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d words pending exp 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
